// File: rtl/bist_engine.sv
// Self-contained BIST engine: LFSR pattern source, CUT input mux, MISR compactor, signature compare.
// Optional macro BIST_PROG_GOLDEN_EN replaces the GOLDEN parameter with a golden_in port sampled in INIT.
module bist_engine #(
  parameter int                IN_W       = 3,
  parameter int                OUT_W      = 3,
  parameter int                LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS  = 16'hB400,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 16'h0001,
  parameter int                MISR_W     = 16,
  parameter logic [MISR_W-1:0] MISR_TAPS  = 16'h8016,
  parameter int                N_PATTERNS = 20000,
  parameter int                CNT_W      = 15,
  parameter logic [MISR_W-1:0] GOLDEN     = 16'h0000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              bist_start,
  input  logic [IN_W-1:0]   func_in,
  input  logic [OUT_W-1:0]  cut_out,
  output logic [IN_W-1:0]   cut_in,
  output logic              scan_en,
  output logic              scan_in,
  output logic              bist_running,
  output logic              bist_end,
  output logic              pass_fail,
  output logic [MISR_W-1:0] signature
`ifdef BIST_PROG_GOLDEN_EN
  ,
  input  logic [MISR_W-1:0] golden_in
`endif
);

  if (N_PATTERNS < 1 || N_PATTERNS > (2**CNT_W) - 1) begin : g_chk_npat
    $error("bist_engine: N_PATTERNS out of range for CNT_W");
  end
  if (OUT_W > MISR_W) begin : g_chk_outw
    $error("bist_engine: OUT_W must not exceed MISR_W");
  end
  if (LFSR_W < IN_W + 1) begin : g_chk_lfsrw
    $error("bist_engine: LFSR_W must be at least IN_W+1");
  end
  if (LFSR_SEED == '0) begin : g_chk_seed
    $error("bist_engine: LFSR_SEED must be nonzero");
  end

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_CMP, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [MISR_W-1:0] misr_q, misr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pf_q, pf_d;
  logic [MISR_W-1:0] golden;
  logic [LFSR_W-1:0] lfsr_step;
  logic [MISR_W-1:0] misr_step;

`ifdef BIST_PROG_GOLDEN_EN
  logic [MISR_W-1:0] golden_q, golden_d;
  assign golden = golden_q;
`else
  assign golden = GOLDEN;
`endif

  assign lfsr_step = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
  assign misr_step = {misr_q[MISR_W-2:0], 1'b0}
                   ^ (misr_q[MISR_W-1] ? MISR_TAPS : '0)
                   ^ MISR_W'(cut_out);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    pf_d    = pf_q;
`ifdef BIST_PROG_GOLDEN_EN
    golden_d = golden_q;
`endif
    case (state_q)
      S_IDLE: if (bist_start) state_d = S_INIT;
      S_INIT: begin
        lfsr_d  = LFSR_SEED;
        misr_d  = '0;
        cnt_d   = '0;
        pf_d    = 1'b0;
`ifdef BIST_PROG_GOLDEN_EN
        golden_d = golden_in;
`endif
        state_d = S_RUN;
      end
      S_RUN: begin
        lfsr_d = lfsr_step;
        misr_d = misr_step;
        cnt_d  = cnt_q + 1'b1;
        // last compaction happens in the same cycle we leave RUN
        if (cnt_q == CNT_W'(N_PATTERNS - 1)) state_d = S_CMP;
      end
      S_CMP: begin
        pf_d    = (misr_q == golden);
        state_d = S_DONE;
      end
      S_DONE: if (!bist_start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      lfsr_q  <= LFSR_SEED;
      misr_q  <= '0;
      cnt_q   <= '0;
      pf_q    <= 1'b0;
`ifdef BIST_PROG_GOLDEN_EN
      golden_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
      pf_q    <= pf_d;
`ifdef BIST_PROG_GOLDEN_EN
      golden_q <= golden_d;
`endif
    end
  end

  assign scan_en      = (state_q == S_RUN);
  assign bist_running = (state_q == S_INIT) || (state_q == S_RUN) || (state_q == S_CMP);
  assign bist_end     = (state_q == S_DONE);
  assign scan_in      = lfsr_q[LFSR_W-1];
  assign cut_in       = scan_en ? lfsr_q[IN_W-1:0] : func_in;
  assign pass_fail    = pf_q;
  assign signature    = misr_q;

endmodule
